// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory bus between the instruction-fetch side
// (imem_*) and the data-access side (dmem_*). One transaction is in flight at
// a time: a request is granted in IDLE, then the block waits in WAIT for
// mem_rvalid and steers the response back to the side that owns the bus.
// A per-transaction timeout turns a missing response into an error response.
//
// Parameters:
//   TIMEOUT_CYCLES - cycles after a grant before an error response is forced
//                    (0 disables the timeout)
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, alternate between sides under
//                        contention; otherwise dmem has fixed priority.
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   imem_req/addr -> imem_gnt/rvalid/rdata/err        - fetch side
//   dmem_req/wr_en/size/addr/wr_data -> dmem_gnt/rvalid/rdata/err - data side
//   mem_req/wr_en/size/addr/wr_data, mem_gnt/rvalid/rdata        - downstream
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_gnt,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  output logic        imem_err,
  input  logic        dmem_req,
  input  logic        dmem_wr_en,
  input  logic [1:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wr_data,
  output logic        dmem_gnt,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rdata,
  output logic        dmem_err,
  output logic        mem_req,
  output logic        mem_wr_en,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [1:0]       SIZE_WORD = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IMEM = 2'd1, OWN_DMEM = 2'd2} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_dmem_s;

  // Internal (ungated) versions of every output.
  logic        mem_req_s, mem_wr_en_s;
  logic [1:0]  mem_size_s;
  logic [31:0] mem_addr_s, mem_wr_data_s;
  logic        imem_gnt_s, dmem_gnt_s;
  logic        resp_valid_s, resp_err_s;
  logic [31:0] resp_data_s;
  logic        imem_rvalid_s, imem_err_s, dmem_rvalid_s, dmem_err_s;
  logic [31:0] imem_rdata_s, dmem_rdata_s;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = dmem was the last side granted, 0 = imem.
  logic last_dmem_q, last_dmem_d;

  // Winner selection: alternate under contention, a lone requester always wins.
  always_comb begin
    if (imem_req && dmem_req) begin
      pick_dmem_s = ~last_dmem_q;
    end else begin
      pick_dmem_s = dmem_req;
    end
  end
`else
  // Winner selection: dmem always beats imem.
  always_comb begin
    pick_dmem_s = dmem_req;
  end
`endif

  // Next-state, downstream request and response generation.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dmem_d   = last_dmem_q;
`endif
    mem_req_s     = 1'b0;
    mem_wr_en_s   = 1'b0;
    mem_size_s    = 2'b00;
    mem_addr_s    = 32'h0000_0000;
    mem_wr_data_s = 32'h0000_0000;
    imem_gnt_s    = 1'b0;
    dmem_gnt_s    = 1'b0;
    resp_valid_s  = 1'b0;
    resp_err_s    = 1'b0;
    resp_data_s   = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (imem_req || dmem_req) begin
          mem_req_s = 1'b1;
          if (pick_dmem_s) begin
            mem_wr_en_s   = dmem_wr_en;
            mem_size_s    = dmem_size;
            mem_addr_s    = dmem_addr;
            mem_wr_data_s = dmem_wr_data;
            dmem_gnt_s    = mem_gnt;
          end else begin
            mem_size_s    = SIZE_WORD;
            mem_addr_s    = imem_addr;
            imem_gnt_s    = mem_gnt;
          end
          if (mem_gnt) begin
            state_d = ST_WAIT;
            owner_d = pick_dmem_s ? OWN_DMEM : OWN_IMEM;
            cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dmem_d = pick_dmem_s;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        // A real response beats a timeout landing in the same cycle.
        if (mem_rvalid) begin
          resp_valid_s = 1'b1;
          resp_data_s  = mem_rdata;
          state_d      = ST_IDLE;
          owner_d      = OWN_NONE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          state_d      = ST_IDLE;
          owner_d      = OWN_NONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Steer the response to the owning side only; the other side stays at zero.
  always_comb begin
    imem_rvalid_s = 1'b0;
    imem_err_s    = 1'b0;
    imem_rdata_s  = 32'h0000_0000;
    dmem_rvalid_s = 1'b0;
    dmem_err_s    = 1'b0;
    dmem_rdata_s  = 32'h0000_0000;
    case (owner_q)
      OWN_IMEM: begin
        imem_rvalid_s = resp_valid_s;
        imem_err_s    = resp_err_s;
        imem_rdata_s  = resp_data_s;
      end
      OWN_DMEM: begin
        dmem_rvalid_s = resp_valid_s;
        dmem_err_s    = resp_err_s;
        dmem_rdata_s  = resp_data_s;
      end
      default: begin
        imem_rvalid_s = 1'b0;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock,
  // so the core and fabric see an idle bus the moment reset_n falls.
  always_comb begin
    if (reset_n) begin
      mem_req     = mem_req_s;
      mem_wr_en   = mem_wr_en_s;
      mem_size    = mem_size_s;
      mem_addr    = mem_addr_s;
      mem_wr_data = mem_wr_data_s;
      imem_gnt    = imem_gnt_s;
      imem_rvalid = imem_rvalid_s;
      imem_rdata  = imem_rdata_s;
      imem_err    = imem_err_s;
      dmem_gnt    = dmem_gnt_s;
      dmem_rvalid = dmem_rvalid_s;
      dmem_rdata  = dmem_rdata_s;
      dmem_err    = dmem_err_s;
    end else begin
      mem_req     = 1'b0;
      mem_wr_en   = 1'b0;
      mem_size    = 2'b00;
      mem_addr    = 32'h0000_0000;
      mem_wr_data = 32'h0000_0000;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
      imem_err    = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0000_0000;
      dmem_err    = 1'b0;
    end
  end

  // State, owner and timeout counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-granted side; reset points at imem so dmem wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_dmem_q <= 1'b0;
    end else begin
      last_dmem_q <= last_dmem_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_wr_en;
  logic [1:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wr_data;
  logic        dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;
  logic        mem_req, mem_wr_en;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t tmp_e;

  logic [137:0] all_out;
  assign all_out = {mem_req, mem_wr_en, mem_size, mem_addr, mem_wr_data,
                    imem_gnt, imem_rvalid, imem_rdata, imem_err,
                    dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err};

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_wr_en(dmem_wr_en), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .mem_req(mem_req), .mem_wr_en(mem_wr_en), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response scoreboard: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (imem_rvalid || dmem_rvalid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_rvalid: got imem_rvalid=%0b dmem_rvalid=%0b, required no response",
                 imem_rvalid, dmem_rvalid);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_d) begin
          if ({imem_rvalid, dmem_rvalid} !== 2'b01 || dmem_rdata !== mon_e.data ||
              dmem_err !== mon_e.err || imem_rdata !== 32'h0 || imem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL dmem_resp: got rv=%b%b rdata=%h err=%b (imem rdata=%h err=%b), required rv=01 rdata=%h err=%b",
                     imem_rvalid, dmem_rvalid, dmem_rdata, dmem_err, imem_rdata, imem_err,
                     mon_e.data, mon_e.err);
          end
        end else begin
          if ({imem_rvalid, dmem_rvalid} !== 2'b10 || imem_rdata !== mon_e.data ||
              imem_err !== mon_e.err || dmem_rdata !== 32'h0 || dmem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL imem_resp: got rv=%b%b rdata=%h err=%b (dmem rdata=%h err=%b), required rv=10 rdata=%h err=%b",
                     imem_rvalid, dmem_rvalid, imem_rdata, imem_err, dmem_rdata, dmem_err,
                     mon_e.data, mon_e.err);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data, input logic err);
    tmp_e.is_d = is_d;
    tmp_e.data = data;
    tmp_e.err  = err;
    sb.push_back(tmp_e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h0000_0040;
    dmem_req = 1'b1; dmem_wr_en = 1'b1; dmem_size = 2'b10;
    dmem_addr = 32'h0000_0080; dmem_wr_data = 32'h1111_2222;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #3;
    n_cmp++;
    if (all_out !== 138'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    imem_req = 1'b0; dmem_req = 1'b0; dmem_wr_en = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #7 reset_n = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++;
    if (all_out !== 138'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, required 0", all_out);
    end
  endtask

  task automatic test_single_fetch();
    cyc();
    imem_req = 1'b1; imem_addr = 32'h0000_0100; mem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_gnt, dmem_gnt, mem_req, mem_wr_en, mem_size} !== 6'b101010 ||
        mem_addr !== 32'h0000_0100 || mem_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_grant: got ignt=%b dgnt=%b req=%b we=%b size=%b addr=%h wd=%h, required 1 0 1 0 10 00000100 0",
               imem_gnt, dmem_gnt, mem_req, mem_wr_en, mem_size, mem_addr, mem_wr_data);
    end
    cyc();
    imem_req = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({imem_gnt, dmem_gnt, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL fetch_wait: got ignt=%b dgnt=%b req=%b, required 000", imem_gnt, dmem_gnt, mem_req);
    end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    push_exp(1'b0, 32'h0050_0093, 1'b0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL fetch_resp_seen: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_contention();
    cyc();
    imem_req = 1'b1; imem_addr = 32'h0000_0104;
    dmem_req = 1'b1; dmem_wr_en = 1'b1; dmem_size = 2'b10;
    dmem_addr = 32'h0000_2000; dmem_wr_data = 32'hDEAD_BEEF;
    mem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dmem_gnt, imem_gnt, mem_wr_en} !== 3'b101 || mem_addr !== 32'h0000_2000 ||
        mem_wr_data !== 32'hDEAD_BEEF || mem_size !== 2'b10) begin
      n_fail++;
      $display("FAIL contention_first: got dgnt=%b ignt=%b we=%b addr=%h wd=%h size=%b, required 1 0 1 00002000 deadbeef 10",
               dmem_gnt, imem_gnt, mem_wr_en, mem_addr, mem_wr_data, mem_size);
    end
    cyc();
    dmem_req = 1'b0; dmem_wr_en = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    push_exp(1'b1, 32'h1234_5678, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({imem_gnt, dmem_gnt, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL contention_wait: got ignt=%b dgnt=%b req=%b, required 000", imem_gnt, dmem_gnt, mem_req);
    end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_gnt, dmem_gnt, mem_wr_en} !== 3'b100 || mem_addr !== 32'h0000_0104 ||
        mem_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL contention_second: got ignt=%b dgnt=%b we=%b addr=%h wd=%h, required 1 0 0 00000104 0",
               imem_gnt, dmem_gnt, mem_wr_en, mem_addr, mem_wr_data);
    end
    cyc();
    imem_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    push_exp(1'b0, 32'hA5A5_5A5A, 1'b0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL contention_resp_seen: got %0d pending, required 0", sb.size());
    end
  endtask

  // Both sides held high for four transactions.
  task automatic test_arbitration();
    logic exp_d;
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      imem_req = 1'b1; imem_addr = 32'h0000_0500 + 32'(i * 4);
      dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = 2'b01;
      dmem_addr = 32'h0000_4000 + 32'(i * 4);
      mem_gnt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(negedge clk);
      n_cmp++;
      if ({dmem_gnt, imem_gnt} !== {exp_d, ~exp_d} ||
          mem_addr !== (exp_d ? (32'h0000_4000 + 32'(i * 4)) : (32'h0000_0500 + 32'(i * 4))) ||
          mem_size !== (exp_d ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got dgnt=%b ignt=%b addr=%h size=%b, required dgnt=%b",
                 i, dmem_gnt, imem_gnt, mem_addr, mem_size, exp_d);
      end
      cyc();
      mem_gnt = 1'b0;
      if (exp_d) dmem_req = 1'b0;
      else imem_req = 1'b0;
      if (i == 3) begin
        imem_req = 1'b0; dmem_req = 1'b0;
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h1000_0000 + 32'(i);
      push_exp(exp_d, 32'h1000_0000 + 32'(i), 1'b0);
    end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL arb_resp_seen: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_timeout();
    cyc();
    dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = 2'b10;
    dmem_addr = 32'h0000_3000; mem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dmem_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_grant: got dgnt=%b, required 1", dmem_gnt);
    end
    cyc();
    dmem_req = 1'b0; mem_gnt = 1'b0;
    repeat (TO - 2) cyc();
    // Grant cycle + TO: error response expected here.
    cyc();
    push_exp(1'b1, 32'h0, 1'b1);
    cyc();
    // Late response after the timeout must be dropped.
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_resp_seen: got %0d pending, required 0", sb.size());
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_req, imem_gnt, dmem_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_resp_idle: got req=%b ignt=%b dgnt=%b, required 000", mem_req, imem_gnt, dmem_gnt);
    end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // Real response in the same cycle the timeout would fire.
  task automatic test_timeout_race();
    cyc();
    imem_req = 1'b1; imem_addr = 32'h0000_0600; mem_gnt = 1'b1;
    cyc();
    imem_req = 1'b0; mem_gnt = 1'b0;
    repeat (TO - 2) cyc();
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    push_exp(1'b0, 32'hCAFE_F00D, 1'b0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL race_resp_seen: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      cyc();
      imem_req = 1'b1; imem_addr = 32'h0000_0200; mem_gnt = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({mem_req, imem_gnt, dmem_gnt} !== 3'b100 || mem_addr !== 32'h0000_0200) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got req=%b ignt=%b dgnt=%b addr=%h, required 1 0 0 00000200",
                 i, mem_req, imem_gnt, dmem_gnt, mem_addr);
      end
    end
    cyc();
    mem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_grant: got ignt=%b, required 1", imem_gnt);
    end
    // Counter starts at the grant, so the timeout lands TO cycles later.
    cyc();
    imem_req = 1'b0; mem_gnt = 1'b0;
    repeat (TO - 2) cyc();
    cyc();
    push_exp(1'b0, 32'h0, 1'b1);
    cyc();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL backpressure_timeout_seen: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_addr = 32'h0000_5000; mem_gnt = 1'b1;
    cyc();
    dmem_req = 1'b0; mem_gnt = 1'b0;
    #2;
    reset_n = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h0000_0700; mem_gnt = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== 138'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0", all_out);
    end
    @(negedge clk);
    #2;
    imem_req = 1'b0; mem_gnt = 1'b0;
    reset_n = 1'b1;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, imem_gnt, dmem_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got req=%b ignt=%b dgnt=%b, required 000", mem_req, imem_gnt, dmem_gnt);
    end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    imem_req = 1'b1; imem_addr = 32'h0000_0300; mem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_gnt !== 1'b1 || mem_addr !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL reset_mid_rearb: got ignt=%b addr=%h, required 1 00000300", imem_gnt, mem_addr);
    end
    cyc();
    imem_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_0001;
    push_exp(1'b0, 32'h7777_0001, 1'b0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_resp_seen: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_arbitration();
    test_timeout();
    test_timeout_race();
    test_backpressure();
    test_reset_mid();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
